// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN datapath controllers: sequencer states and
// default lane/channel geometry.
package cnn_ctrl_pkg;

  localparam int unsigned DataSizeDef  = 16;
  localparam int unsigned ArraySizeDef = 9;
  localparam int unsigned ChWDef       = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StAccum = 2'd2,
    StHold  = 2'd3
  } ctrl_st_e;

endpackage

// File: rtl/lane_mask_reg.sv
// Load-enabled multi-lane register; on load, lanes outside the mask are
// stored as zero.
module lane_mask_reg
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned data_size  = DataSizeDef,
  parameter int unsigned array_size = ArraySizeDef
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load,
  input  logic [array_size-1:0]            mask,
  input  logic [array_size*data_size-1:0]  d,
  output logic [array_size*data_size-1:0]  q
);

  logic [array_size*data_size-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      for (int i = 0; i < int'(array_size); i++) begin
        q_d[i*data_size +: data_size] = mask[i] ? d[i*data_size +: data_size] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bias_accum_ctrl.sv
// Bias-load / accumulate sequencer for the per-lane adder bank; captures the
// finished tile and offers it downstream over valid/ready.
module bias_accum_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned data_size  = DataSizeDef,
  parameter int unsigned array_size = ArraySizeDef,
  parameter int unsigned ch_w       = ChWDef
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ch_w-1:0]                  num_channels,
  input  logic [array_size-1:0]            lane_mask,
  input  logic                             mac_valid,
  output logic                             mac_ready,
  output logic                             mode,
  output logic [array_size-1:0]            enable,
  input  logic [array_size-1:0]            adder_done,
  input  logic [array_size*data_size-1:0]  acc_in,
  output logic [array_size*data_size-1:0]  out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             cfg_err,
  output logic                             lane_err
);

  localparam logic [ch_w-1:0] CntOne = ch_w'(1);

  ctrl_st_e                st_d, st_q;
  logic [ch_w-1:0]         nch_d, nch_q;
  logic [ch_w-1:0]         cnt_d, cnt_q;
  logic [array_size-1:0]   mask_d, mask_q;
  logic                    lane_err_d, lane_err_q;
  logic                    cfg_err_d, cfg_err_q;
  logic                    out_valid_d, out_valid_q;
  logic                    capture;

  always_comb begin
    st_d        = st_q;
    nch_d       = nch_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    lane_err_d  = lane_err_q;
    cfg_err_d   = 1'b0;
    out_valid_d = out_valid_q;
    capture     = 1'b0;
    mode        = 1'b0;
    enable      = '0;
    mac_ready   = 1'b0;

    unique case (st_q)
      StIdle: begin
        if (start) begin
          if (num_channels == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            nch_d      = num_channels;
            mask_d     = lane_mask;
            cnt_d      = '0;
            lane_err_d = 1'b0;
            st_d       = StLoad;
          end
        end
      end
      StLoad: begin
        mode   = 1'b1;
        enable = mask_q;
        st_d   = StAccum;
      end
      StAccum: begin
        mac_ready = 1'b1;
        if (mac_valid) begin
          enable = mask_q;
          cnt_d  = cnt_q + CntOne;
          if (adder_done != mask_q) lane_err_d = 1'b1;
          // Compare against N-1 so N = 2^ch_w - 1 finishes before the counter wraps.
          if (cnt_q == nch_q - CntOne) begin
            capture     = 1'b1;
            out_valid_d = 1'b1;
            st_d        = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          st_d        = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= StIdle;
      nch_q       <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      lane_err_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      nch_q       <= nch_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      lane_err_q  <= lane_err_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  lane_mask_reg #(
    .data_size  (data_size),
    .array_size (array_size)
  ) u_out_reg (
    .clk   (clk),
    .reset (reset),
    .load  (capture),
    .mask  (mask_q),
    .d     (acc_in),
    .q     (out_data)
  );

  assign busy      = (st_q != StIdle);
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
  assign lane_err  = lane_err_q;

endmodule

// File: tb/tb_bias_accum_ctrl.sv
// Directed, table-driven bench for bias_accum_ctrl with hand-written reset
// and long-count sequences.
module tb_bias_accum_ctrl;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int CW = 8;
  localparam int F  = 'h1ff;
  localparam int M  = 'h00f;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CW-1:0]     num_channels;
  logic [AW-1:0]     lane_mask;
  logic              mac_valid;
  logic              mac_ready;
  logic              mode;
  logic [AW-1:0]     enable;
  logic [AW-1:0]     adder_done;
  logic [AW*DW-1:0]  acc_in;
  logic [AW*DW-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              cfg_err;
  logic              lane_err;

  int n_cmp = 0;
  int n_err = 0;

  bias_accum_ctrl #(
    .data_size  (DW),
    .array_size (AW),
    .ch_w       (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_channels (num_channels),
    .lane_mask    (lane_mask),
    .mac_valid    (mac_valid),
    .mac_ready    (mac_ready),
    .mode         (mode),
    .enable       (enable),
    .adder_done   (adder_done),
    .acc_in       (acc_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .cfg_err      (cfg_err),
    .lane_err     (lane_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic [CW-1:0] nch;
    logic [AW-1:0] msk;
    logic          mv;
    logic [AW-1:0] dn;
    logic [15:0]   ab;
    logic          ordy;
    logic          e_mode;
    logic [AW-1:0] e_en;
    logic          e_mrdy;
    logic          e_ov;
    logic          e_busy;
    logic          e_cfg;
    logic          e_lerr;
    logic [15:0]   e_ob;
    logic [AW-1:0] e_om;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(input int st, input int n, input int m, input int mv, input int dn,
                              input int ab, input int ordy, input int emode, input int een,
                              input int emrdy, input int eov, input int ebusy, input int ecfg,
                              input int elerr, input int eob, input int eom);
    vec_t r;
    r.st = 1'(st);     r.nch = CW'(n);     r.msk = AW'(m);     r.mv = 1'(mv);
    r.dn = AW'(dn);    r.ab = 16'(ab);     r.ordy = 1'(ordy);  r.e_mode = 1'(emode);
    r.e_en = AW'(een); r.e_mrdy = 1'(emrdy); r.e_ov = 1'(eov); r.e_busy = 1'(ebusy);
    r.e_cfg = 1'(ecfg); r.e_lerr = 1'(elerr); r.e_ob = 16'(eob); r.e_om = AW'(eom);
    return r;
  endfunction

  // Lane i carries base+i; lanes outside m are zero.
  function automatic logic [AW*DW-1:0] fill(input int base, input int m);
    logic [AW*DW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) begin
      if (m[i]) r[i*DW +: DW] = DW'(base + i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [AW*DW-1:0] act,
                     input logic [AW*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_tile(input int n, input int m, input string name);
    int  acc_cnt = 0;
    int  ov_cyc  = -1;
    bit  seen    = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; num_channels = CW'(n); lane_mask = AW'(m); mac_valid = 1'b1;
    adder_done = AW'(m); out_ready = 1'b1; acc_in = fill(0, F);
    for (int c = 1; c <= n + 10 && !seen; c++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      acc_in = fill(c, F);
      @(negedge clk);
      if (out_valid) begin
        seen   = 1'b1;
        ov_cyc = c;
      end else if (mac_ready && mac_valid) begin
        acc_cnt++;
      end
    end
    chk({name, " out_valid seen within budget"}, seen, 1'b1);
    chk({name, " accept count"}, acc_cnt, n);
    chk({name, " out_valid cycle"}, ov_cyc, n + 2);
    chk({name, " out_data"}, out_data, fill(n + 1, m));
    @(posedge clk); #1;
    mac_valid = 1'b0;
    @(negedge clk);
    chk({name, " idle after accept"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; num_channels = '0; lane_mask = '0; mac_valid = 1'b0;
    adder_done = '0; acc_in = fill('h5555, F); out_ready = 1'b0;

    // Basic tile, N=3, back-to-back beats.
    v.push_back(mk(1, 3, F, 1, F, 'h1000, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    v.push_back(mk(0, 3, F, 1, F, 'h1001, 1,  1, F, 0, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 3, F, 1, F, 'h1002, 1,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 3, F, 1, F, 'h1003, 1,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 3, F, 1, F, 'h1004, 1,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 3, F, 1, F, 'h1005, 1,  0, 0, 0, 1, 1, 0, 0,  'h1004, F));
    v.push_back(mk(0, 3, F, 0, F, 'h1006, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    // Bubbles 1,0,1,0,0,1,1 then three stalled HOLD cycles.
    v.push_back(mk(1, 4, F, 0, F, 'h2000, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    v.push_back(mk(0, 4, F, 1, F, 'h2001, 0,  1, F, 0, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 4, F, 1, F, 'h2002, 0,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 4, F, 0, F, 'h2003, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 4, F, 1, F, 'h2004, 0,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 4, F, 0, F, 'h2005, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 4, F, 0, F, 'h2006, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 4, F, 1, F, 'h2007, 0,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 4, F, 1, F, 'h2008, 0,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 4, F, 1, F, 'h2009, 0,  0, 0, 0, 1, 1, 0, 0,  'h2008, F));
    v.push_back(mk(0, 4, F, 1, F, 'h200a, 0,  0, 0, 0, 1, 1, 0, 0,  'h2008, F));
    v.push_back(mk(0, 4, F, 1, F, 'h200b, 0,  0, 0, 0, 1, 1, 0, 0,  'h2008, F));
    v.push_back(mk(0, 4, F, 1, F, 'h200c, 1,  0, 0, 0, 1, 1, 0, 0,  'h2008, F));
    v.push_back(mk(0, 4, F, 0, F, 'h200d, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    // N=0 start, then starts during ACCUM and on the HOLD->IDLE edge.
    v.push_back(mk(1, 0, F, 0, F, 'h3000, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    v.push_back(mk(0, 0, F, 0, F, 'h3000, 0,  0, 0, 0, 0, 0, 1, 0,  0, 0));
    v.push_back(mk(0, 0, F, 0, F, 'h3000, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    v.push_back(mk(1, 2, F, 0, F, 'h3000, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    v.push_back(mk(0, 2, F, 0, F, 'h3001, 0,  1, F, 0, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(1, 0, F, 0, F, 'h3001, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(1, 7, F, 1, F, 'h3002, 0,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 7, F, 1, F, 'h3003, 0,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(1, 3, F, 1, F, 'h3004, 1,  0, 0, 0, 1, 1, 0, 0,  'h3003, F));
    v.push_back(mk(0, 3, F, 0, F, 'h3005, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    v.push_back(mk(0, 3, F, 0, F, 'h3006, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    // Mask 00F, lane mismatch on beat 2; then an N=1 tile clears lane_err.
    v.push_back(mk(1, 2, M, 0, M, 'h4000, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0));
    v.push_back(mk(0, 2, M, 1, M, 'h4001, 0,  1, M, 0, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 2, M, 1, M, 'h4010, 0,  0, M, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 2, M, 1, 'h007, 'h4020, 0,  0, M, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 2, M, 1, 'h007, 'h4030, 0,  0, 0, 0, 1, 1, 0, 1,  'h4020, M));
    v.push_back(mk(0, 2, M, 0, M, 'h4031, 1,  0, 0, 0, 1, 1, 0, 1,  'h4020, M));
    v.push_back(mk(1, 1, F, 0, F, 'h4040, 1,  0, 0, 0, 0, 0, 0, 1,  0, 0));
    v.push_back(mk(0, 1, F, 1, F, 'h4050, 1,  1, F, 0, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 1, F, 1, F, 'h4060, 1,  0, F, 1, 0, 1, 0, 0,  0, 0));
    v.push_back(mk(0, 1, F, 1, F, 'h4070, 1,  0, 0, 0, 1, 1, 0, 0,  'h4060, F));
    v.push_back(mk(0, 1, F, 0, F, 'h4080, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset mode", mode, 1'b0);
    chk("reset enable", enable, '0);
    chk("reset mac_ready", mac_ready, 1'b0);
    chk("reset out_data", out_data, '0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset cfg_err", cfg_err, 1'b0);
    chk("reset lane_err", lane_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (v[i]) begin
      @(posedge clk); #1;
      start = v[i].st; num_channels = v[i].nch; lane_mask = v[i].msk; mac_valid = v[i].mv;
      adder_done = v[i].dn; acc_in = fill(int'(v[i].ab), F); out_ready = v[i].ordy;
      @(negedge clk);
      chk($sformatf("row %0d mode", i), mode, v[i].e_mode);
      chk($sformatf("row %0d enable", i), enable, v[i].e_en);
      chk($sformatf("row %0d mac_ready", i), mac_ready, v[i].e_mrdy);
      chk($sformatf("row %0d out_valid", i), out_valid, v[i].e_ov);
      chk($sformatf("row %0d busy", i), busy, v[i].e_busy);
      chk($sformatf("row %0d cfg_err", i), cfg_err, v[i].e_cfg);
      chk($sformatf("row %0d lane_err", i), lane_err, v[i].e_lerr);
      if (v[i].e_ov) begin
        chk($sformatf("row %0d out_data", i), out_data,
            fill(int'(v[i].e_ob), int'(v[i].e_om)));
      end
    end

    // Reset on beat 2 of a 5-beat tile, with lane_err already set.
    @(posedge clk); #1;
    start = 1'b1; num_channels = 8'd5; lane_mask = AW'(F); mac_valid = 1'b0;
    adder_done = AW'(F); out_ready = 1'b1; acc_in = fill('h5000, F);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    mac_valid = 1'b1; adder_done = 9'h0f0;
    @(posedge clk); #1;
    adder_done = AW'(F);
    chk("mid-tile busy before reset", busy, 1'b1);
    chk("mid-tile lane_err before reset", lane_err, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async reset mode", mode, 1'b0);
    chk("async reset enable", enable, '0);
    chk("async reset mac_ready", mac_ready, 1'b0);
    chk("async reset out_data", out_data, '0);
    chk("async reset out_valid", out_valid, 1'b0);
    chk("async reset busy", busy, 1'b0);
    chk("async reset lane_err", lane_err, 1'b0);
    chk("async reset cfg_err", cfg_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset out_valid c%0d", c), out_valid, 1'b0);
      chk($sformatf("post-reset busy c%0d", c), busy, 1'b0);
    end
    mac_valid = 1'b0;

    run_tile(3, F, "fresh tile N=3");
    run_tile(2, 'h0a5, "masked tile N=2");
    run_tile(255, F, "max tile N=255");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
